// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader.
//   state_e        : loader FSM states (VFY is only reachable when the design
//                    is built with PROG_LOADER_VERIFY_EN defined)
//   BYTES_PER_WORD : byte stores per 32-bit instruction word
//   byte_lane()    : picks little-endian byte k out of a 32-bit word, which is
//                    the order the core's four-cycle fetch rebuilds its IR in
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WRB  = 3'd2,
    VFY  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Byte k = 0 is bits [7:0], byte k = 3 is bits [31:24].
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  k);
    return word[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Boot-time program loader for the 8-bit multicycle MIPS core. Accepts 32-bit
// instruction words over a valid/ready stream and writes each one into the
// byte-wide unified memory as four consecutive little-endian byte stores,
// holding the core in reset until the whole image has been written.
//
// Optional feature (macro PROG_LOADER_VERIFY_EN): after each word's four byte
// writes, a four-cycle VFY pass reads the bytes back through mem_rd_i and
// sets the sticky error flag on any mismatch. With the macro undefined there
// is no VFY pass and mem_rd_i is unused.
//
// Parameters:
//   ADDR_W    : memory byte-address width
//   BASE_ADDR : byte address of the first instruction written
//   MAX_WORDS : maximum words per load; hitting it without word_last is an error
//
// Ports:
//   clk_i        : system clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   start_i      : one-cycle pulse starting a load (honoured in IDLE/DONE only)
//   word_valid_i : word_data_i / word_last_i are valid
//   word_data_i  : 32-bit instruction word
//   word_last_i  : marks the final word of the image
//   word_ready_o : loader accepts a word this cycle
//   mem_adr_o    : memory byte address
//   mem_wd_o     : memory write data
//   mem_we_o     : memory write enable
//   mem_rd_i     : combinational memory read data of mem_adr_o
//   cpu_hold_o   : holds the core in reset
//   busy_o       : high in LOAD, WRB and VFY
//   done_o       : high in DONE
//   err_o        : sticky error, cleared by start
// ---------------------------------------------------------------------------
module prog_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          MAX_WORDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              word_valid_i,
  input  logic [31:0]       word_data_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [7:0]        mem_wd_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_rd_i,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam int                WCNT_W    = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] MAX_CNT   = WCNT_W'(MAX_WORDS);
  localparam logic [1:0]        LAST_LANE = 2'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  // Set on the cycle that finishes a word; end_cnt is the word count that
  // includes that word, used for the MAX_WORDS overflow check.
  logic                word_end;
  logic [WCNT_W-1:0]   end_cnt;

`ifndef PROG_LOADER_VERIFY_EN
  // Read-back data only matters for the verify pass.
  logic unused_mem_rd;
  assign unused_mem_rd = ^mem_rd_i;
`endif

  // State and datapath registers; a reset mid-load drops the partial word
  // but leaves bytes already stored in memory untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      cnt_q   <= 2'd0;
      wcnt_q  <= '0;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: LOAD takes one word, WRB serialises it a byte per
  // cycle, and the end-of-word decision is shared by WRB and VFY below.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    word_d   = word_q;
    last_d   = last_q;
    err_d    = err_q;
    word_end = 1'b0;
    end_cnt  = wcnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = LOAD;
          ptr_d   = BASE;
          wcnt_d  = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (word_valid_i) begin
          word_d  = word_data_i;
          last_d  = word_last_i;
          cnt_d   = 2'd0;
          state_d = WRB;
        end
      end

      WRB: begin
        // ptr wraps modulo 2^ADDR_W without any special handling.
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LANE) begin
          wcnt_d = wcnt_q + 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
          // The counter wraps to 0, ready for the read-back pass.
          state_d = VFY;
`else
          word_end = 1'b1;
          end_cnt  = wcnt_d;
`endif
        end
      end

`ifdef PROG_LOADER_VERIFY_EN
      VFY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rd_i != byte_lane(word_q, cnt_q)) begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST_LANE) begin
          word_end = 1'b1;
          end_cnt  = wcnt_q;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (word_end) begin
      if (last_q) begin
        state_d = DONE;
      end else if (end_cnt == MAX_CNT) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    word_ready_o = (state_q == LOAD);
    mem_we_o     = (state_q == WRB);
    busy_o       = (state_q == LOAD) || (state_q == WRB) || (state_q == VFY);
    done_o       = (state_q == DONE);
    cpu_hold_o   = (state_q != DONE);
    err_o        = err_q;
    mem_wd_o     = 8'd0;
    mem_adr_o    = ptr_q;
    if (state_q == WRB) begin
      mem_wd_o = byte_lane(word_q, cnt_q);
    end
    if (state_q == VFY) begin
      // ptr already points past the word; step back to byte k of it.
      mem_adr_o = ptr_q - ADDR_W'(BYTES_PER_WORD) + ADDR_W'(cnt_q);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed self-checking bench for prog_loader. Three instances share clock
// and reset: u0 uses default parameters, u1 has BASE_ADDR=0x10, and u2 has
// BASE_ADDR=0xFE with MAX_WORDS=2. Each instance has its own byte-wide
// memory model; when PROG_LOADER_VERIFY_EN is defined, u0's memory returns
// corrupted data when address 0x02 is read.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int NDUT = 3;
`ifdef PROG_LOADER_VERIFY_EN
  localparam int   VFY_CYC    = 4;
  localparam logic SINGLE_ERR = 1'b1;
`else
  localparam int   VFY_CYC    = 0;
  localparam logic SINGLE_ERR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [NDUT-1:0]       start, word_valid, word_last;
  logic [NDUT-1:0][31:0] word_data;
  logic [NDUT-1:0]       word_ready, mem_we, cpu_hold, busy, done, err;
  logic [NDUT-1:0][7:0]  mem_adr, mem_wd, mem_rd;
  logic [7:0]            mem [NDUT][256];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  prog_loader u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]),
    .word_valid_i(word_valid[0]), .word_data_i(word_data[0]), .word_last_i(word_last[0]),
    .word_ready_o(word_ready[0]), .mem_adr_o(mem_adr[0]), .mem_wd_o(mem_wd[0]),
    .mem_we_o(mem_we[0]), .mem_rd_i(mem_rd[0]), .cpu_hold_o(cpu_hold[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
  );

  prog_loader #(.BASE_ADDR(8'h10)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]),
    .word_valid_i(word_valid[1]), .word_data_i(word_data[1]), .word_last_i(word_last[1]),
    .word_ready_o(word_ready[1]), .mem_adr_o(mem_adr[1]), .mem_wd_o(mem_wd[1]),
    .mem_we_o(mem_we[1]), .mem_rd_i(mem_rd[1]), .cpu_hold_o(cpu_hold[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
  );

  prog_loader #(.BASE_ADDR(8'hFE), .MAX_WORDS(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]),
    .word_valid_i(word_valid[2]), .word_data_i(word_data[2]), .word_last_i(word_last[2]),
    .word_ready_o(word_ready[2]), .mem_adr_o(mem_adr[2]), .mem_wd_o(mem_wd[2]),
    .mem_we_o(mem_we[2]), .mem_rd_i(mem_rd[2]), .cpu_hold_o(cpu_hold[2]),
    .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2])
  );

  // Byte-wide memories written on the rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (mem_we[i]) mem[i][mem_adr[i]] <= mem_wd[i];
    end
  end

  // Combinational read port; u0 may return a corrupted byte at 0x02.
  always_comb begin
    for (int i = 0; i < NDUT; i++) mem_rd[i] = mem[i][mem_adr[i]];
`ifdef PROG_LOADER_VERIFY_EN
    if (mem_adr[0] == 8'h02) mem_rd[0] = mem[0][8'h02] ^ 8'hFF;
`endif
  end

  // Starts a load with a one-cycle pulse; returns on the next falling edge.
  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Holds a word valid until accepted or the budget runs out; on acceptance
  // returns at the falling edge of the first byte-write cycle.
  task automatic offer_word(input int d, input logic [31:0] w, input logic last,
                            input int budget, output logic ok);
    ok = 1'b0;
    word_valid[d] = 1'b1;
    word_data[d]  = w;
    word_last[d]  = last;
    for (int i = 0; i < budget; i++) begin
      if (word_ready[d]) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    word_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    start = '0; word_valid = '0; word_last = '0; word_data = '0;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_we[0], word_ready[0], cpu_hold[0], busy[0], done[0], err[0]} !== 6'b001000) begin
      $display("[TB] FAIL reset_flags: got we/rdy/hold/busy/done/err=%b required 001000",
               {mem_we[0], word_ready[0], cpu_hold[0], busy[0], done[0], err[0]});
    end else passes++;
    checks++;
    if (mem_adr[0] !== 8'h00 || mem_wd[0] !== 8'h00) begin
      $display("[TB] FAIL reset_mem_bus: got adr=%h wd=%h required 00 00", mem_adr[0], mem_wd[0]);
    end else passes++;
    checks++;
    if (mem_adr[1] !== 8'h10) begin
      $display("[TB] FAIL reset_base_u1: got adr=%h required 10", mem_adr[1]);
    end else passes++;
    checks++;
    if (mem_adr[2] !== 8'hFE) begin
      $display("[TB] FAIL reset_base_u2: got adr=%h required fe", mem_adr[2]);
    end else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // A word offered in IDLE without start must not be taken.
    word_valid[0] = 1'b1;
    word_data[0]  = 32'h12345678;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (word_ready[0] !== 1'b0 || mem_we[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
    end
    word_valid[0] = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      $display("[TB] FAIL idle_ignores_word: got activity=%b required 0", bad);
    end else passes++;
  endtask

  task automatic test_single_word();
    logic ok;
    logic [7:0] exp [4] = '{8'h05, 8'h00, 8'h0A, 8'h8C};
    // start and word_valid together in IDLE: only start acts.
    word_valid[0] = 1'b1;
    word_data[0]  = 32'h8C0A0005;
    word_last[0]  = 1'b1;
    pulse_start(0);
    checks++;
    if (word_ready[0] !== 1'b1 || mem_we[0] !== 1'b0 || busy[0] !== 1'b1) begin
      $display("[TB] FAIL start_only: got rdy/we/busy=%b%b%b required 101",
               word_ready[0], mem_we[0], busy[0]);
    end else passes++;
    offer_word(0, 32'h8C0A0005, 1'b1, 5, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL single_accept: got accepted=%b required 1", ok);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we[0] !== 1'b1 || mem_adr[0] !== 8'(k) || mem_wd[0] !== exp[k]) begin
        $display("[TB] FAIL single_byte%0d: got we=%b adr=%h wd=%h required 1 %h %h",
                 k, mem_we[0], mem_adr[0], mem_wd[0], 8'(k), exp[k]);
      end else passes++;
      @(negedge clk);
    end
`ifdef PROG_LOADER_VERIFY_EN
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we[0] !== 1'b0 || mem_adr[0] !== 8'(k) || busy[0] !== 1'b1) begin
        $display("[TB] FAIL verify_read%0d: got we=%b adr=%h busy=%b required 0 %h 1",
                 k, mem_we[0], mem_adr[0], busy[0], 8'(k));
      end else passes++;
      @(negedge clk);
    end
`endif
    checks++;
    if (done[0] !== 1'b1 || cpu_hold[0] !== 1'b0 || busy[0] !== 1'b0 || word_ready[0] !== 1'b0) begin
      $display("[TB] FAIL single_done: got done/hold/busy/rdy=%b%b%b%b required 1000",
               done[0], cpu_hold[0], busy[0], word_ready[0]);
    end else passes++;
    checks++;
    if (err[0] !== SINGLE_ERR) $display("[TB] FAIL single_err: got %b required %b", err[0], SINGLE_ERR);
    else passes++;
    checks++;
    if (mem[0][0] !== 8'h05 || mem[0][1] !== 8'h00 || mem[0][2] !== 8'h0A || mem[0][3] !== 8'h8C) begin
      $display("[TB] FAIL single_mem: got %h %h %h %h required 05 00 0a 8c",
               mem[0][0], mem[0][1], mem[0][2], mem[0][3]);
    end else passes++;
  endtask

  task automatic test_start_ignored();
    logic ok;
    pulse_start(0);
    offer_word(0, 32'h01020304, 1'b0, 5, ok);
    checks++;
    if (ok !== 1'b1 || mem_adr[0] !== 8'h00 || mem_wd[0] !== 8'h04) begin
      $display("[TB] FAIL restart_byte0: got ok=%b adr=%h wd=%h required 1 00 04", ok, mem_adr[0], mem_wd[0]);
    end else passes++;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checks++;
    if (mem_we[0] !== 1'b1 || mem_adr[0] !== 8'h01 || mem_wd[0] !== 8'h03) begin
      $display("[TB] FAIL start_in_wrb_k1: got we=%b adr=%h wd=%h required 1 01 03", mem_we[0], mem_adr[0], mem_wd[0]);
    end else passes++;
    @(negedge clk);
    checks++;
    if (mem_adr[0] !== 8'h02 || mem_wd[0] !== 8'h02) begin
      $display("[TB] FAIL start_in_wrb_k2: got adr=%h wd=%h required 02 02", mem_adr[0], mem_wd[0]);
    end else passes++;
    repeat (2 + VFY_CYC) @(negedge clk);
    checks++;
    if (word_ready[0] !== 1'b1 || done[0] !== 1'b0 || mem_adr[0] !== 8'h04) begin
      $display("[TB] FAIL not_last_back_to_load: got rdy=%b done=%b adr=%h required 1 0 04",
               word_ready[0], done[0], mem_adr[0]);
    end else passes++;
  endtask

  task automatic test_gaps();
    logic ok;
    logic [31:0] words [3] = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};
    logic [7:0] ea;
    logic [7:0] ed;
    logic bad;
    pulse_start(1);
    for (int w = 0; w < 3; w++) begin
      offer_word(1, words[w], w == 2, 10, ok);
      checks++;
      if (ok !== 1'b1) $display("[TB] FAIL gap_accept%0d: got accepted=%b required 1", w, ok);
      else passes++;
      for (int k = 0; k < 4; k++) begin
        ea = 8'(8'h10 + 4 * w + k);
        ed = words[w][8 * k +: 8];
        checks++;
        if (mem_we[1] !== 1'b1 || mem_adr[1] !== ea || mem_wd[1] !== ed || word_ready[1] !== 1'b0) begin
          $display("[TB] FAIL gap_w%0d_b%0d: got we=%b adr=%h wd=%h rdy=%b required 1 %h %h 0",
                   w, k, mem_we[1], mem_adr[1], mem_wd[1], word_ready[1], ea, ed);
        end else passes++;
        @(negedge clk);
      end
      bad = 1'b0;
      for (int v = 0; v < VFY_CYC; v++) begin
        if (word_ready[1] !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      if (w < 2) begin
        checks++;
        if (word_ready[1] !== 1'b1 || bad !== 1'b0) begin
          $display("[TB] FAIL gap_ready_back%0d: got rdy=%b early=%b required 1 0", w, word_ready[1], bad);
        end else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (word_ready[1] !== 1'b1 || mem_we[1] !== 1'b0) begin
          $display("[TB] FAIL gap_wait%0d: got rdy=%b we=%b required 1 0", w, word_ready[1], mem_we[1]);
        end else passes++;
      end
    end
    checks++;
    if (done[1] !== 1'b1 || err[1] !== 1'b0 || cpu_hold[1] !== 1'b0) begin
      $display("[TB] FAIL gap_done: got done/err/hold=%b%b%b required 100", done[1], err[1], cpu_hold[1]);
    end else passes++;
  endtask

  task automatic test_wrap();
    logic ok;
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start(2);
    offer_word(2, 32'h44332211, 1'b1, 5, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL wrap_accept: got accepted=%b required 1", ok);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we[2] !== 1'b1 || mem_adr[2] !== ea[k] || mem_wd[2] !== ed[k]) begin
        $display("[TB] FAIL wrap_byte%0d: got we=%b adr=%h wd=%h required 1 %h %h",
                 k, mem_we[2], mem_adr[2], mem_wd[2], ea[k], ed[k]);
      end else passes++;
      @(negedge clk);
    end
    repeat (VFY_CYC) @(negedge clk);
    checks++;
    if (done[2] !== 1'b1 || err[2] !== 1'b0) begin
      $display("[TB] FAIL wrap_done: got done=%b err=%b required 1 0", done[2], err[2]);
    end else passes++;
  endtask

  task automatic test_max_words();
    logic ok;
    pulse_start(2);
    offer_word(2, 32'h00000001, 1'b0, 5, ok);
    repeat (4 + VFY_CYC) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || word_ready[2] !== 1'b1 || err[2] !== 1'b0) begin
      $display("[TB] FAIL max_word1: got ok=%b rdy=%b err=%b required 1 1 0", ok, word_ready[2], err[2]);
    end else passes++;
    offer_word(2, 32'h00000002, 1'b0, 5, ok);
    repeat (4 + VFY_CYC) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || done[2] !== 1'b1 || err[2] !== 1'b1 || busy[2] !== 1'b0) begin
      $display("[TB] FAIL max_overflow: got ok=%b done=%b err=%b busy=%b required 1 1 1 0",
               ok, done[2], err[2], busy[2]);
    end else passes++;
    offer_word(2, 32'h00000003, 1'b0, 8, ok);
    checks++;
    if (ok !== 1'b0 || mem_we[2] !== 1'b0) begin
      $display("[TB] FAIL max_third_refused: got accepted=%b we=%b required 0 0", ok, mem_we[2]);
    end else passes++;
    checks++;
    if (err[2] !== 1'b1 || done[2] !== 1'b1) begin
      $display("[TB] FAIL max_err_sticky: got err=%b done=%b required 1 1", err[2], done[2]);
    end else passes++;
    pulse_start(2);
    checks++;
    if (err[2] !== 1'b0 || word_ready[2] !== 1'b1 || mem_adr[2] !== 8'hFE) begin
      $display("[TB] FAIL start_clears_err: got err=%b rdy=%b adr=%h required 0 1 fe",
               err[2], word_ready[2], mem_adr[2]);
    end else passes++;
  endtask

  task automatic test_reset_mid_load();
    logic ok;
    offer_word(0, 32'hCAFEF00D, 1'b1, 5, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || mem_we[0] !== 1'b1 || mem_adr[0] !== 8'h06 || mem_wd[0] !== 8'hFE) begin
      $display("[TB] FAIL midload_k2: got ok=%b we=%b adr=%h wd=%h required 1 1 06 fe",
               ok, mem_we[0], mem_adr[0], mem_wd[0]);
    end else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we[0], word_ready[0], cpu_hold[0], busy[0], done[0], err[0]} !== 6'b001000) begin
      $display("[TB] FAIL midload_reset_flags: got we/rdy/hold/busy/done/err=%b required 001000",
               {mem_we[0], word_ready[0], cpu_hold[0], busy[0], done[0], err[0]});
    end else passes++;
    checks++;
    if (mem_adr[0] !== 8'h00 || mem_wd[0] !== 8'h00) begin
      $display("[TB] FAIL midload_reset_bus: got adr=%h wd=%h required 00 00", mem_adr[0], mem_wd[0]);
    end else passes++;
    checks++;
    if (mem[0][4] !== 8'h0D || mem[0][5] !== 8'hF0) begin
      $display("[TB] FAIL midload_kept_bytes: got %h %h required 0d f0", mem[0][4], mem[0][5]);
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_hold[0] !== 1'b1 || busy[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
      $display("[TB] FAIL midload_idle_after: got hold=%b busy=%b we=%b required 1 0 0",
               cpu_hold[0], busy[0], mem_we[0]);
    end else passes++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_start_ignored();
    test_gaps();
    test_wrap();
    test_max_words();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000ns required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
